flip_icon_buffer: RTL and testbench

// - Local storage for flip icons, directly upstream of the flip engine.
// - Host streams icons in through a valid/ready write port. The flip engine reads them back through a
//   1-cycle-latency read port (ren/raddr -> rdata).
// - Publishes icon_last_raddr_plus_one_o, the number of valid icons. The engine uses it to detect icon exhaustion.

---
 rtl/flip_icon_buffer.sv | 113 +++++++++++
 tb/tb_flip_icon_buffer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/flip_icon_buffer.sv
// Icon store in front of the flip engine. The host loads icons through a valid/ready port,
// and the engine reads them back with a 1-cycle latency once the icon set is complete.
module flip_icon_buffer #(
  parameter int DATASPIN             = 256,
  parameter int FLIP_ICON_DEPTH      = 1024,
  parameter int FLIP_ICON_ADDR_DEPTH = $clog2(FLIP_ICON_DEPTH)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic                            flush_i,
  input  logic                            load_start_i,
  input  logic                            icon_wvalid_i,
  input  logic [DATASPIN-1:0]             icon_wdata_i,
  input  logic                            icon_wlast_i,
  output logic                            icon_wready_o,
  output logic                            load_done_o,
  input  logic                            flip_ren_i,
  input  logic [FLIP_ICON_ADDR_DEPTH:0]   flip_raddr_i,
  output logic [DATASPIN-1:0]             flip_rdata_o,
  output logic [FLIP_ICON_ADDR_DEPTH:0]   icon_last_raddr_plus_one_o,
  output logic                            rd_err_o
);

  localparam int AW = FLIP_ICON_ADDR_DEPTH;
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(FLIP_ICON_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state, state_n;
  logic [PW-1:0] wr_ptr, wr_ptr_n;
  logic [PW-1:0] lpo, lpo_n;
  logic          we;
  logic          rd_ok;

  logic [DATASPIN-1:0] mem [FLIP_ICON_DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      wr_ptr <= '0;
      lpo    <= '0;
    end else begin
      state  <= state_n;
      wr_ptr <= wr_ptr_n;
      lpo    <= lpo_n;
    end
  end

  // Everything here is gated by en_i so a disabled cycle leaves the FSM untouched.
  always_comb begin
    state_n       = state;
    wr_ptr_n      = wr_ptr;
    lpo_n         = lpo;
    icon_wready_o = 1'b0;
    we            = 1'b0;
    if (en_i) begin
      case (state)
        IDLE, DONE: begin
          if (load_start_i) begin
            state_n  = LOAD;
            wr_ptr_n = '0;
            lpo_n    = '0;
          end
        end
        LOAD: begin
          icon_wready_o = 1'b1;
          if (flush_i) begin
            state_n = IDLE;
            lpo_n   = '0;
          end else if (icon_wvalid_i) begin
            we       = 1'b1;
            wr_ptr_n = wr_ptr + 1'b1;
            if (icon_wlast_i || wr_ptr == LAST_IDX) begin
              state_n = DONE;
              lpo_n   = wr_ptr + 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) mem[wr_ptr[AW-1:0]] <= icon_wdata_i;
  end

  assign rd_ok = (state == DONE) && (flip_raddr_i < lpo);

  // Rejected reads return an all-zero icon, which the engine treats as "no flip".
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flip_rdata_o <= '0;
      rd_err_o     <= 1'b0;
    end else begin
      rd_err_o <= 1'b0;
      if (en_i && flip_ren_i) begin
        if (rd_ok) begin
          flip_rdata_o <= mem[flip_raddr_i[AW-1:0]];
        end else begin
          flip_rdata_o <= '0;
          rd_err_o     <= 1'b1;
        end
      end
    end
  end

  assign load_done_o                = (state == DONE);
  assign icon_last_raddr_plus_one_o = lpo;

endmodule

// File: tb/tb_flip_icon_buffer.sv
// Directed bench for flip_icon_buffer: load, capacity cap, enable gating, flush, reload, reset.
module tb_flip_icon_buffer;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int AW = 2;

  logic          clk_i = 1'b0;
  logic          rst_i, en_i, flush_i, load_start_i;
  logic          icon_wvalid_i, icon_wlast_i, icon_wready_o, load_done_o;
  logic [DW-1:0] icon_wdata_i, flip_rdata_o;
  logic          flip_ren_i, rd_err_o;
  logic [AW:0]   flip_raddr_i, icon_last_raddr_plus_one_o;

  int checks = 0;
  int errors = 0;

  flip_icon_buffer #(.DATASPIN(DW), .FLIP_ICON_DEPTH(DEPTH), .FLIP_ICON_ADDR_DEPTH(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .flush_i(flush_i),
    .load_start_i(load_start_i), .icon_wvalid_i(icon_wvalid_i),
    .icon_wdata_i(icon_wdata_i), .icon_wlast_i(icon_wlast_i),
    .icon_wready_o(icon_wready_o), .load_done_o(load_done_o),
    .flip_ren_i(flip_ren_i), .flip_raddr_i(flip_raddr_i),
    .flip_rdata_o(flip_rdata_o),
    .icon_last_raddr_plus_one_o(icon_last_raddr_plus_one_o),
    .rd_err_o(rd_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_load();
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
  endtask

  task automatic put(input logic [DW-1:0] d, input logic last);
    icon_wvalid_i = 1'b1;
    icon_wdata_i  = d;
    icon_wlast_i  = last;
    tick();
    icon_wvalid_i = 1'b0;
    icon_wlast_i  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [AW:0] a, input logic [DW-1:0] exp, input logic err);
    flip_ren_i   = 1'b1;
    flip_raddr_i = a;
    tick();
    flip_ren_i   = 1'b0;
    chk({tag, "_data"}, 64'(flip_rdata_o), 64'(exp));
    chk({tag, "_err"}, 64'(rd_err_o), 64'(err));
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b1; flush_i = 1'b0; load_start_i = 1'b0;
    icon_wvalid_i = 1'b0; icon_wdata_i = '0; icon_wlast_i = 1'b0;
    flip_ren_i = 1'b0; flip_raddr_i = '0;
    tick(); tick();
    chk("rst_wready", 64'(icon_wready_o), 64'd0);
    chk("rst_done", 64'(load_done_o), 64'd0);
    chk("rst_lpo", 64'(icon_last_raddr_plus_one_o), 64'd0);
    chk("rst_rdata", 64'(flip_rdata_o), 64'd0);
    chk("rst_err", 64'(rd_err_o), 64'd0);
    rst_i = 1'b0;

    // three words A,B,C with wlast on C
    start_load();
    icon_wvalid_i = 1'b1; #1;
    chk("load_wready", 64'(icon_wready_o), 64'd1);
    icon_wvalid_i = 1'b0;
    put(32'hA, 1'b0);
    put(32'hB, 1'b0);
    chk("pre_done", 64'(load_done_o), 64'd0);
    put(32'hC, 1'b1);
    chk("abc_done", 64'(load_done_o), 64'd1);
    chk("abc_lpo", 64'(icon_last_raddr_plus_one_o), 64'd3);
    chk("done_wready", 64'(icon_wready_o), 64'd0);
    rd("rd0", 3'd0, 32'hA, 1'b0);
    rd("rd1", 3'd1, 32'hB, 1'b0);
    rd("rd2", 3'd2, 32'hC, 1'b0);
    rd("rd3", 3'd3, 32'h0, 1'b1);
    rd("rd1b", 3'd1, 32'hB, 1'b0);
    tick();
    chk("hold_data", 64'(flip_rdata_o), 64'hB);
    chk("hold_err", 64'(rd_err_o), 64'd0);

    // six words without wlast into a 4-deep store
    start_load();
    icon_wvalid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      icon_wdata_i = DW'(32'h10 + i);
      tick();
      if (i == 3) begin
        chk("cap_wready", 64'(icon_wready_o), 64'd0);
        chk("cap_done", 64'(load_done_o), 64'd1);
      end
    end
    icon_wvalid_i = 1'b0;
    chk("cap_lpo", 64'(icon_last_raddr_plus_one_o), 64'd4);
    rd("cap_rd0", 3'd0, 32'h10, 1'b0);
    rd("cap_rd3", 3'd3, 32'h13, 1'b0);
    rd("cap_rd4", 3'd4, 32'h0, 1'b1);

    // en_i toggled low every other cycle during the load
    start_load();
    for (int i = 0; i < 3; i++) begin
      en_i = 1'b0;
      icon_wvalid_i = 1'b1;
      icon_wdata_i = DW'(32'h20 + i);
      icon_wlast_i = (i == 2);
      #1;
      chk("en0_wready", 64'(icon_wready_o), 64'd0);
      tick();
      en_i = 1'b1;
      tick();
    end
    icon_wvalid_i = 1'b0; icon_wlast_i = 1'b0;
    chk("en_lpo", 64'(icon_last_raddr_plus_one_o), 64'd3);
    chk("en_done", 64'(load_done_o), 64'd1);
    rd("en_rd0", 3'd0, 32'h20, 1'b0);
    rd("en_rd1", 3'd1, 32'h21, 1'b0);
    rd("en_rd2", 3'd2, 32'h22, 1'b0);
    en_i = 1'b0;
    rd("en_off_rd", 3'd0, 32'h22, 1'b0);
    en_i = 1'b1;

    // flush after two of five words; the third word is offered in the flush cycle
    start_load();
    put(32'h30, 1'b0);
    put(32'h31, 1'b0);
    flush_i = 1'b1;
    put(32'h32, 1'b0);
    flush_i = 1'b0;
    chk("flush_done", 64'(load_done_o), 64'd0);
    chk("flush_lpo", 64'(icon_last_raddr_plus_one_o), 64'd0);
    icon_wvalid_i = 1'b1; #1;
    chk("flush_wready", 64'(icon_wready_o), 64'd0);
    icon_wvalid_i = 1'b0;
    rd("flush_rd", 3'd0, 32'h0, 1'b1);

    // reload while DONE
    start_load();
    put(32'h40, 1'b0);
    put(32'h41, 1'b1);
    chk("rl1_lpo", 64'(icon_last_raddr_plus_one_o), 64'd2);
    start_load();
    chk("rl_done_drop", 64'(load_done_o), 64'd0);
    chk("rl_lpo_clr", 64'(icon_last_raddr_plus_one_o), 64'd0);
    put(32'h50, 1'b0);
    put(32'h51, 1'b1);
    chk("rl2_done", 64'(load_done_o), 64'd1);
    chk("rl2_lpo", 64'(icon_last_raddr_plus_one_o), 64'd2);
    rd("rl2_rd1", 3'd1, 32'h51, 1'b0);

    // reset in the middle of a load
    start_load();
    put(32'h60, 1'b0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mrst_done", 64'(load_done_o), 64'd0);
    chk("mrst_lpo", 64'(icon_last_raddr_plus_one_o), 64'd0);
    chk("mrst_rdata", 64'(flip_rdata_o), 64'd0);
    chk("mrst_err", 64'(rd_err_o), 64'd0);
    icon_wvalid_i = 1'b1; #1;
    chk("mrst_wready", 64'(icon_wready_o), 64'd0);
    icon_wvalid_i = 1'b0;
    tick();
    chk("mrst_idle", 64'(load_done_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
